// File: rtl/gpu.sv
// Write-only APB 2D raster engine: latches a colour and two corners, then streams
// one clipped pixel per clock in raster order for PIXEL, RECT and CLEAR commands.
module gpu #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [31:0]             pAddr_i,
  input  logic [31:0]             pDataWrite_i,
  input  logic                    pSel_i,
  input  logic                    pEnable_i,
  input  logic                    pWrite_i,
  output logic [WIDTH_BITS-1:0]   x_o,
  output logic [HEIGHT_BITS-1:0]  y_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    data_avail
);

  localparam logic [7:0] ADDR_COLOR = 8'h00;
  localparam logic [7:0] ADDR_P1    = 8'h04;
  localparam logic [7:0] ADDR_P2    = 8'h08;
  localparam logic [7:0] ADDR_CMD   = 8'h0C;

  localparam logic [1:0] CMD_PIXEL = 2'd0;
  localparam logic [1:0] CMD_RECT  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;
  localparam logic [1:0] CMD_NOP   = 2'd3;

  localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(SCREEN_H - 1);

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CHANNEL_BITS-1:0] r_col_r, r_col_g, r_col_b;
  logic [WIDTH_BITS-1:0]   r_p1_x, r_p2_x;
  logic [HEIGHT_BITS-1:0]  r_p1_y, r_p2_y;

  logic [WIDTH_BITS-1:0]   r_xmin, r_xmax, r_x;
  logic [HEIGHT_BITS-1:0]  r_ymax, r_y;
  logic [CHANNEL_BITS-1:0] r_pix_r, r_pix_g, r_pix_b;
  logic                    r_avail;

  logic                    w_wr;
  logic [7:0]              w_addr;
  logic [1:0]              w_cmd;
  logic                    w_cmd_wr;
  logic                    w_start;
  logic                    w_last;
  logic [WIDTH_BITS-1:0]   w_c1x, w_c2x, w_xmin, w_xmax;
  logic [HEIGHT_BITS-1:0]  w_c1y, w_c2y, w_ymin, w_ymax;
  logic                    w_unused;

  assign w_wr     = pSel_i & pEnable_i & pWrite_i;
  assign w_addr   = pAddr_i[7:0];
  assign w_cmd    = pDataWrite_i[1:0];
  assign w_cmd_wr = w_wr && (w_addr == ADDR_CMD) && (w_cmd != CMD_NOP);
  assign w_start  = (r_state == S_IDLE) && w_cmd_wr;
  assign w_last   = (r_x == r_xmax) && (r_y == r_ymax);
  assign w_unused = ^{pAddr_i[31:8], pDataWrite_i};

  // Clip each corner to the screen, then order the bounds for the selected command.
  always_comb begin
    w_c1x  = (r_p1_x > X_LAST) ? X_LAST : r_p1_x;
    w_c2x  = (r_p2_x > X_LAST) ? X_LAST : r_p2_x;
    w_c1y  = (r_p1_y > Y_LAST) ? Y_LAST : r_p1_y;
    w_c2y  = (r_p2_y > Y_LAST) ? Y_LAST : r_p2_y;
    w_xmin = w_c1x;
    w_xmax = w_c1x;
    w_ymin = w_c1y;
    w_ymax = w_c1y;
    case (w_cmd)
      CMD_RECT: begin
        w_xmin = (w_c1x < w_c2x) ? w_c1x : w_c2x;
        w_xmax = (w_c1x < w_c2x) ? w_c2x : w_c1x;
        w_ymin = (w_c1y < w_c2y) ? w_c1y : w_c2y;
        w_ymax = (w_c1y < w_c2y) ? w_c2y : w_c1y;
      end
      CMD_CLEAR: begin
        w_xmin = '0;
        w_xmax = X_LAST;
        w_ymin = '0;
        w_ymax = Y_LAST;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_DRAW;
      S_DRAW: if (w_last)  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Register file, command snapshot and raster walk; the first pixel launches on the CMD edge.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_col_r <= '0;
      r_col_g <= '0;
      r_col_b <= '0;
      r_p1_x  <= '0;
      r_p1_y  <= '0;
      r_p2_x  <= '0;
      r_p2_y  <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pix_r <= '0;
      r_pix_g <= '0;
      r_pix_b <= '0;
      r_avail <= 1'b0;
    end else begin
      if (w_wr && (w_addr == ADDR_COLOR)) begin
        r_col_r <= pDataWrite_i[16 +: CHANNEL_BITS];
        r_col_g <= pDataWrite_i[8  +: CHANNEL_BITS];
        r_col_b <= pDataWrite_i[0  +: CHANNEL_BITS];
      end
      if (w_wr && (w_addr == ADDR_P1)) begin
        r_p1_x <= pDataWrite_i[0  +: WIDTH_BITS];
        r_p1_y <= pDataWrite_i[16 +: HEIGHT_BITS];
      end
      if (w_wr && (w_addr == ADDR_P2)) begin
        r_p2_x <= pDataWrite_i[0  +: WIDTH_BITS];
        r_p2_y <= pDataWrite_i[16 +: HEIGHT_BITS];
      end

      if (w_start) begin
        r_xmin  <= w_xmin;
        r_xmax  <= w_xmax;
        r_ymax  <= w_ymax;
        r_x     <= w_xmin;
        r_y     <= w_ymin;
        r_pix_r <= r_col_r;
        r_pix_g <= r_col_g;
        r_pix_b <= r_col_b;
        r_avail <= 1'b1;
      end else if (r_state == S_DRAW) begin
        if (w_last) begin
          r_avail <= 1'b0;
        end else if (r_x == r_xmax) begin
          r_x <= r_xmin;
          r_y <= r_y + HEIGHT_BITS'(1);
        end else begin
          r_x <= r_x + WIDTH_BITS'(1);
        end
      end
    end
  end

  assign x_o        = r_x;
  assign y_o        = r_y;
  assign r_o        = r_pix_r;
  assign g_o        = r_pix_g;
  assign b_o        = r_pix_b;
  assign data_avail = r_avail;

endmodule

// File: tb/tb_gpu.sv
// Directed and randomized checks of the gpu raster engine against a pixel-list model.
module tb_gpu;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] pAddr_i, pDataWrite_i;
  logic        pSel_i, pEnable_i, pWrite_i;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        data_avail;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  pix_t exp_q[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   m_r, m_g, m_b, m_x1, m_y1, m_x2, m_y2;

  gpu dut (
    .clk(clk), .n_rst(n_rst), .pAddr_i(pAddr_i), .pDataWrite_i(pDataWrite_i),
    .pSel_i(pSel_i), .pEnable_i(pEnable_i), .pWrite_i(pWrite_i),
    .x_o(x_o), .y_o(y_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .data_avail(data_avail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clipv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_r = 0; m_g = 0; m_b = 0; m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0;
    exp_q.delete();
  endtask

  // Expected pixel list for a command issued while idle.
  task automatic build(input int cmd);
    int x0, x1, y0, y1;
    pix_t p;
    exp_q.delete();
    if (cmd == 3) return;
    if (cmd == 2) begin
      x0 = 0; x1 = 639; y0 = 0; y1 = 479;
    end else if (cmd == 0) begin
      x0 = clipv(m_x1, 639); x1 = x0; y0 = clipv(m_y1, 479); y1 = y0;
    end else begin
      x0 = clipv((m_x1 < m_x2) ? m_x1 : m_x2, 639);
      x1 = clipv((m_x1 < m_x2) ? m_x2 : m_x1, 639);
      y0 = clipv((m_y1 < m_y2) ? m_y1 : m_y2, 479);
      y1 = clipv((m_y1 < m_y2) ? m_y2 : m_y1, 479);
    end
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        p.x = 10'(x); p.y = 9'(y); p.r = 8'(m_r); p.g = 8'(m_g); p.b = 8'(m_b);
        exp_q.push_back(p);
      end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input bit idle);
    case (a & 32'hFF)
      32'h00: begin m_r = int'((d >> 16) & 255); m_g = int'((d >> 8) & 255); m_b = int'(d & 255); end
      32'h04: begin m_x1 = int'(d & 1023); m_y1 = int'((d >> 16) & 511); end
      32'h08: begin m_x2 = int'(d & 1023); m_y2 = int'((d >> 16) & 511); end
      32'h0C: if (idle) build(int'(d & 3));
      default: ;
    endcase
  endtask

  task automatic bus_idle();
    pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0; pAddr_i = '0; pDataWrite_i = '0;
  endtask

  // Setup + access phase write; returns at the negedge after the accepting edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    pSel_i = 1'b1; pWrite_i = 1'b1; pEnable_i = 1'b0; pAddr_i = a; pDataWrite_i = d;
    @(negedge clk);
    pEnable_i = 1'b1;
    @(negedge clk);
    bus_idle();
    model_write(a, d, 1'b1);
  endtask

  // Check the pixel stream cycle by cycle, optionally injecting single-cycle writes.
  task automatic drain(input int ca, input logic [31:0] aa, input logic [31:0] da,
                       input int cb, input logic [31:0] ab, input logic [31:0] db);
    pix_t last;
    int   n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("avail_on", 64'(data_avail), 64'd1);
      check("pixel", 64'({x_o, y_o, r_o, g_o, b_o}), 64'(exp_q[i]));
      last = exp_q[i];
      if (i == ca || i == cb) begin
        pSel_i = 1'b1; pEnable_i = 1'b1; pWrite_i = 1'b1;
        pAddr_i = (i == ca) ? aa : ab; pDataWrite_i = (i == ca) ? da : db;
        model_write(pAddr_i, pDataWrite_i, 1'b0);
      end else begin
        bus_idle();
      end
      @(negedge clk);
    end
    bus_idle();
    check("avail_off", 64'(data_avail), 64'd0);
    if (n > 0) check("hold_xy", 64'({x_o, y_o}), 64'({last.x, last.y}));
    @(negedge clk);
    check("avail_stay_off", 64'(data_avail), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus_idle();
    model_reset();
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_avail", 64'(data_avail), 64'd0);
    check("rst_out", 64'({x_o, y_o, r_o, g_o, b_o}), 64'd0);
    n_rst = 1'b0;

    apb_write(32'h0C, 32'h0);
    drain(-1, 0, 0, -1, 0, 0);

    apb_write(32'h00, 32'h00FF8010);
    apb_write(32'h04, (32'd7 << 16) | 32'd5);
    apb_write(32'h0C, 32'h0);
    drain(-1, 0, 0, -1, 0, 0);

    apb_write(32'h04, (32'd3 << 16) | 32'd2);
    apb_write(32'h08, (32'd4 << 16) | 32'd3);
    apb_write(32'h0C, 32'h1);
    drain(-1, 0, 0, -1, 0, 0);

    apb_write(32'h04, (32'd500 << 16) | 32'd700);
    apb_write(32'h08, (32'd478 << 16) | 32'd638);
    apb_write(32'h0C, 32'h1);
    drain(-1, 0, 0, -1, 0, 0);

    apb_write(32'h04, (32'd10 << 16) | 32'd10);
    apb_write(32'h08, (32'd11 << 16) | 32'd11);
    apb_write(32'h0C, 32'h1);
    drain(1, 32'h00, 32'h000000FF, 2, 32'h0C, 32'h0);
    apb_write(32'h0C, 32'h0);
    drain(-1, 0, 0, -1, 0, 0);

    apb_write(32'h0C, 32'h2);
    for (int i = 0; i < 10; i++) begin
      check("clr_avail", 64'(data_avail), 64'd1);
      check("clr_pixel", 64'({x_o, y_o, r_o, g_o, b_o}), 64'(exp_q[i]));
      if (i == 9) n_rst = 1'b1;
      @(negedge clk);
    end
    n_rst = 1'b0;
    model_reset();
    check("abort_avail", 64'(data_avail), 64'd0);
    check("abort_out", 64'({x_o, y_o, r_o, g_o, b_o}), 64'd0);
    @(negedge clk);
    check("abort_stay", 64'(data_avail), 64'd0);

    apb_write(32'h00, 32'h00123456);
    apb_write(32'h04, (32'd479 << 16) | 32'd639);
    apb_write(32'h0C, 32'h0);
    drain(-1, 0, 0, -1, 0, 0);

    for (int it = 0; it < 30; it++) begin
      int x1, x2, y1, y2, cmd;
      logic [31:0] hi;
      hi = $urandom & 32'hFFFF_FF00;
      x1 = int'($urandom_range(0, 1023));
      y1 = int'($urandom_range(0, 511));
      x2 = x1 + int'($urandom_range(0, 8)) - 4;
      y2 = y1 + int'($urandom_range(0, 6)) - 3;
      x2 = (x2 < 0) ? 0 : ((x2 > 1023) ? 1023 : x2);
      y2 = (y2 < 0) ? 0 : ((y2 > 511) ? 511 : y2);
      cmd = (($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 1)));
      apb_write(hi | 32'h00, $urandom);
      apb_write(hi | 32'h04, ($urandom & 32'hFE00_FC00) | (32'(y1) << 16) | 32'(x1));
      apb_write(hi | 32'h08, ($urandom & 32'hFE00_FC00) | (32'(y2) << 16) | 32'(x2));
      apb_write(hi | 32'h14, $urandom);
      apb_write(hi | 32'h0C, ($urandom & 32'hFFFF_FFFC) | 32'(cmd));
      drain(-1, 0, 0, -1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
